// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit combinational ALU: accepts one request, drives a/b/s with a
// select-change preamble, waits a fixed settle time, then holds the captured result and flags.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [7:0] alu_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic [2:0] out_op,
  output logic       out_zero,
  output logic       out_cy,
  output logic       out_dz
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, PRIME, SETTLE, HOLD} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic          accept_c, prime_c, count_c, capture_c;
  logic [8:0]    sum9_c;
  logic [15:0]   prod16_c;
  logic          cy_c, dz_c;
  logic [7:0]    y_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d   = state;
    accept_c  = 1'b0;
    prime_c   = 1'b0;
    count_c   = 1'b0;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = PRIME;
        end
      end
      PRIME: begin
        prime_c = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          capture_c = 1'b1;
          state_d   = HOLD;
        end else begin
          count_c = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags come from the registered operands, not from the ALU result
  always_comb begin
    sum9_c   = {1'b0, alu_a} + {1'b0, alu_b};
    prod16_c = 16'(alu_a) * 16'(alu_b);
    dz_c     = (op_q == 3'b011) && (alu_b == 8'h00);
    case (op_q)
      3'b000:  cy_c = sum9_c[8];
      3'b001:  cy_c = alu_a < alu_b;
      3'b010:  cy_c = prod16_c > 16'd255;
      default: cy_c = 1'b0;
    endcase
    y_c = dz_c ? 8'hFF : alu_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      op_q     <= '0;
      cnt      <= '0;
      out_y    <= '0;
      out_op   <= '0;
      out_zero <= 1'b0;
      out_cy   <= 1'b0;
      out_dz   <= 1'b0;
    end else begin
      if (accept_c) begin
        alu_a <= in_a;
        alu_b <= in_b;
        op_q  <= in_op;
        alu_s <= in_op ^ 3'b001;
      end
      if (prime_c) begin
        alu_s <= op_q;
        cnt   <= '0;
      end
      if (count_c) cnt <= cnt + CW'(1);
      if (capture_c) begin
        out_y    <= y_c;
        out_op   <= op_q;
        out_zero <= (y_c == 8'h00);
        out_cy   <= cy_c;
        out_dz   <= dz_c;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

endmodule
